// File: rtl/eq_pkg.sv
// Shared constants, coefficient typedef and address helpers for the IIR equaliser.
// Coefficient map: b0..bORDER from B_BASE, then a1..aORDER from a_base(ORDER).
package eq_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 18;
    localparam int DEF_FRAC_W = 14;
    localparam int DEF_ORDER  = 2;

    localparam int B_BASE   = 0;
    localparam int A_BASE   = DEF_ORDER + 1;
    localparam int COEF_ONE = 1 << DEF_FRAC_W;

    typedef logic signed [DEF_COEF_W-1:0] coef_t;

    function automatic int max_addr(input int order);
        return 2 * order;
    endfunction

    function automatic int a_base(input int order);
        return order + 1;
    endfunction

endpackage

// File: rtl/eq_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC_W and clip to DATA_W.
// clipped_o flags that y_o was forced to a rail.
module eq_round_sat #(
    parameter int ACC_W  = 38,
    parameter int FRAC_W = 14,
    parameter int DATA_W = 16
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] y_o,
    output logic              clipped_o
);

    localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        rounded   = $signed(acc_i) + HALF;
        shifted   = rounded >>> FRAC_W;
        y_o       = shifted[DATA_W-1:0];
        clipped_o = 1'b0;
        if (shifted > MAXV) begin
            y_o       = MAXV[DATA_W-1:0];
            clipped_o = 1'b1;
        end else if (shifted < MINV) begin
            y_o       = MINV[DATA_W-1:0];
            clipped_o = 1'b1;
        end
    end

endmodule

// File: rtl/iir_eq_core.sv
// Direct-form-I IIR equaliser with shadow/active coefficient banks, rounding,
// saturation and a threshold slicer. Optional saturation counter: EQ_SAT_CNT_EN.
module iir_eq_core
    import eq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int FRAC_W = 14,
    parameter int ORDER  = 2,
    parameter int ACC_W  = DATA_W + COEF_W + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] slice_thr,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bit,
    output logic              sat,
    output logic [15:0]       sat_count
);

    localparam int NCOEF = max_addr(ORDER) + 1;
    localparam int AB    = a_base(ORDER);
    localparam logic signed [COEF_W-1:0] ONE_C = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC_W;

    logic signed [COEF_W-1:0] shadow_q [NCOEF];
    logic signed [COEF_W-1:0] shadow_d [NCOEF];
    logic signed [COEF_W-1:0] active_q [NCOEF];
    logic signed [COEF_W-1:0] active_d [NCOEF];

    logic signed [DATA_W-1:0] xHist_q [1:ORDER];
    logic signed [DATA_W-1:0] xHist_d [1:ORDER];
    logic signed [DATA_W-1:0] yHist_q [1:ORDER];
    logic signed [DATA_W-1:0] yHist_d [1:ORDER];

    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] outData_q,  outData_d;
    logic              outBit_q,   outBit_d;
    logic              sat_q,      sat_d;

    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] yRound;
    logic                     clipped;

    function automatic logic signed [ACC_W-1:0] sextD(input logic signed [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sextC(input logic signed [COEF_W-1:0] v);
        return {{(ACC_W-COEF_W){v[COEF_W-1]}}, v};
    endfunction

    // A write in the commit cycle is merged into the shadow before it is copied.
    always_comb begin
        for (int k = 0; k < NCOEF; k++) begin
            shadow_d[k] = shadow_q[k];
            if (cfg_wr && (cfg_addr == 3'(k))) begin
                shadow_d[k] = cfg_data;
            end
        end
        for (int k = 0; k < NCOEF; k++) begin
            active_d[k] = cfg_commit ? shadow_d[k] : active_q[k];
        end
    end

    always_comb begin
        acc = sextD($signed(in_data)) * sextC(active_q[B_BASE]);
        for (int k = 1; k <= ORDER; k++) begin
            acc = acc + sextD(xHist_q[k]) * sextC(active_q[B_BASE+k])
                      + sextD(yHist_q[k]) * sextC(active_q[AB+k-1]);
        end
    end

    eq_round_sat #(
        .ACC_W  (ACC_W),
        .FRAC_W (FRAC_W),
        .DATA_W (DATA_W)
    ) u_round_sat (
        .acc_i     (acc),
        .y_o       (yRound),
        .clipped_o (clipped)
    );

    // clear wins over in_valid; without a sample the history and outputs hold.
    always_comb begin
        for (int k = 1; k <= ORDER; k++) begin
            xHist_d[k] = xHist_q[k];
            yHist_d[k] = yHist_q[k];
        end
        outValid_d = 1'b0;
        outData_d  = outData_q;
        outBit_d   = outBit_q;
        sat_d      = 1'b0;
        if (clear) begin
            for (int k = 1; k <= ORDER; k++) begin
                xHist_d[k] = '0;
                yHist_d[k] = '0;
            end
        end else if (in_valid) begin
            outValid_d = 1'b1;
            outData_d  = yRound;
            outBit_d   = (yRound >= $signed(slice_thr));
            sat_d      = clipped;
            xHist_d[1] = $signed(in_data);
            yHist_d[1] = yRound;
            for (int k = 2; k <= ORDER; k++) begin
                xHist_d[k] = xHist_q[k-1];
                yHist_d[k] = yHist_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NCOEF; k++) begin
                shadow_q[k] <= (k == B_BASE) ? ONE_C : '0;
                active_q[k] <= (k == B_BASE) ? ONE_C : '0;
            end
            for (int k = 1; k <= ORDER; k++) begin
                xHist_q[k] <= '0;
                yHist_q[k] <= '0;
            end
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outBit_q   <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            for (int k = 0; k < NCOEF; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
            for (int k = 1; k <= ORDER; k++) begin
                xHist_q[k] <= xHist_d[k];
                yHist_q[k] <= yHist_d[k];
            end
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outBit_q   <= outBit_d;
            sat_q      <= sat_d;
        end
    end

`ifdef EQ_SAT_CNT_EN
    logic [15:0] satCnt_q, satCnt_d;

    // Sticks at all-ones rather than wrapping.
    always_comb begin
        satCnt_d = satCnt_q;
        if (clear) begin
            satCnt_d = '0;
        end else if (sat_d && (satCnt_q != 16'hFFFF)) begin
            satCnt_d = satCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            satCnt_q <= '0;
        end else begin
            satCnt_q <= satCnt_d;
        end
    end

    assign sat_count = satCnt_q;
`else
    assign sat_count = 16'h0000;
`endif

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_bit   = outBit_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_iir_eq_core.sv
// Table-driven bench for iir_eq_core: one vector row per clock, outputs checked
// just after the edge that consumed the row, plus a short hold sequence.
module tb_iir_eq_core;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] slice_thr;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [17:0] cfg_data;
    logic        cfg_commit;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_bit;
    logic        sat;
    logic [15:0] sat_count;

    int total = 0;
    int bad   = 0;
    int expCnt = 0;

    typedef struct {
        logic        rstN;
        logic        clr;
        logic        iv;
        logic [15:0] din;
        logic [15:0] thr;
        logic        wr;
        logic [2:0]  addr;
        logic [17:0] wdata;
        logic        commit;
        logic        expV;
        logic [15:0] expD;
        logic        expB;
        logic        expS;
    } vec_t;

    vec_t vecs[$];

    iir_eq_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .slice_thr  (slice_thr),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_bit    (out_bit),
        .sat        (sat),
        .sat_count  (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rstN, clr, iv, input logic [15:0] din, thr,
                                input logic wr, input logic [2:0] addr, input logic [17:0] wdata,
                                input logic commit, input logic expV, input logic [15:0] expD,
                                input logic expB, expS);
        vec_t v;
        v.rstN = rstN; v.clr = clr; v.iv = iv; v.din = din; v.thr = thr;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.commit = commit;
        v.expV = expV; v.expD = expD; v.expB = expB; v.expS = expS;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n      = v.rstN;
        clear      = v.clr;
        in_valid   = v.iv;
        in_data    = v.din;
        slice_thr  = v.thr;
        cfg_wr     = v.wr;
        cfg_addr   = v.addr;
        cfg_data   = v.wdata;
        cfg_commit = v.commit;
    endtask

    task automatic checkOutput(input string name, input int row,
                               input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic checkAll(input int row, input vec_t v);
`ifdef EQ_SAT_CNT_EN
        logic [15:0] wantCnt = 16'(expCnt);
`else
        logic [15:0] wantCnt = 16'h0000;
`endif
        checkOutput("out_valid", row, {15'd0, out_valid}, {15'd0, v.expV});
        checkOutput("out_data",  row, out_data, v.expD);
        checkOutput("out_bit",   row, {15'd0, out_bit}, {15'd0, v.expB});
        checkOutput("sat",       row, {15'd0, sat}, {15'd0, v.expS});
        checkOutput("sat_count", row, sat_count, wantCnt);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; slice_thr = '0;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;

        //                 rstN clr iv din       thr       wr addr wdata     cm  V  D         B  S
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'h1000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h1000, 1, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 0, 16'h1000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 3'd1, 18'h02000, 0, 0, 16'h1000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 1, 0, 16'h1000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h4000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h2000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h4000, 1, 0));
        vecs.push_back(mk(1, 1, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 0, 0, 16'h4000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 3'd1, 18'h00000, 0, 0, 16'h0000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 3'd3, 18'h02000, 1, 0, 16'h0000, 1, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 0, 16'h0000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h4000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h2000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h1000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h0800, 1, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 0, 16'h0800, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h4000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h2000, 1, 0));
        vecs.push_back(mk(0, 0, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'h1000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h1000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 3'd0, 18'h08000, 1, 0, 16'h1000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h6000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h7FFF, 1, 1));
        vecs.push_back(mk(1, 0, 1, 16'hA000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h8000, 0, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 0, 16'h8000, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0100, 16'h0200, 0, 3'd0, 18'h00000, 0, 1, 16'h0200, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0100, 16'h0201, 0, 3'd0, 18'h00000, 0, 1, 16'h0200, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'hFF00, 16'hFE01, 0, 3'd0, 18'h00000, 0, 1, 16'hFE00, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'hFF00, 16'hFE00, 0, 3'd0, 18'h00000, 0, 1, 16'hFE00, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 3'd0, 18'h04000, 1, 0, 16'hFE00, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 3'd0, 18'h02000, 0, 0, 16'hFE00, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 1, 1, 16'h4000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h2000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 3'd5, 18'h07FFF, 1, 0, 16'h2000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 3'd7, 18'h10000, 1, 0, 16'h2000, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h2000, 1, 0));

        foreach (vecs[i]) begin
            v = vecs[i];
            applyStimulus(v);
            if (!v.rstN || v.clr) expCnt = 0;
            else if (v.expS) expCnt++;
            @(posedge clk);
            #1;
            checkAll(i, v);
        end

        // Idle cycles with garbage on the inputs must leave outputs and history untouched.
        for (int j = 0; j < 3; j++) begin
            v = mk(1, 0, 0, 16'h7000, 16'h7FFF, 0, 3'd0, 18'h00000, 0, 0, 16'h2000, 1, 0);
            applyStimulus(v);
            @(posedge clk);
            #1;
            checkAll(100 + j, v);
        end
        v = mk(1, 0, 1, 16'h4000, 16'h0000, 0, 3'd0, 18'h00000, 0, 1, 16'h2000, 1, 0);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkAll(103, v);

        v = mk(1, 1, 0, 16'h0000, 16'h0000, 0, 3'd0, 18'h00000, 0, 0, 16'h2000, 1, 0);
        expCnt = 0;
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkAll(104, v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
